// File: rtl/xadc_poller_pkg.sv
// Shared definitions for the XADC Wishbone poller: channel indices, the
// DRP address table swept by the poller and the FSM state encoding.
package xadc_poller_pkg;

  localparam int NCH = 4;
  localparam int CHW = 2;

  localparam logic [CHW-1:0] CH_TEMP   = 2'd0;
  localparam logic [CHW-1:0] CH_VCCINT = 2'd1;
  localparam logic [CHW-1:0] CH_VCCAUX = 2'd2;
  localparam logic [CHW-1:0] CH_VBRAM  = 2'd3;

  // Address bit that selects the DRP window inside the XADC wrapper.
  localparam int DRP_WINDOW_BIT = 7;

  localparam logic [6:0] DRP_TEMP   = 7'h00;
  localparam logic [6:0] DRP_VCCINT = 7'h01;
  localparam logic [6:0] DRP_VCCAUX = 7'h02;
  localparam logic [6:0] DRP_VBRAM  = 7'h06;

  // Index 0 lives in the least significant slot.
  localparam logic [NCH*7-1:0] DRP_TABLE = {DRP_VBRAM, DRP_VCCAUX, DRP_VCCINT, DRP_TEMP};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [6:0] drp_addr(input logic [CHW-1:0] ch);
    return DRP_TABLE[int'(ch)*7 +: 7];
  endfunction

endpackage

// File: rtl/xadc_wb_poller.sv
// Autonomous Wishbone read master that periodically sweeps the XADC status
// registers through the wrapper's DRP window and keeps a shadow bank of
// 12-bit results with per-channel valid flags.
// Optional temperature min/max tracking: define XADC_POLLER_MINMAX_EN.
module xadc_wb_poller
  import xadc_poller_pkg::*;
#(
  parameter int aw        = 8,
  parameter int dw        = 16,
  parameter int PERIOD    = 100000,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic          wb_clk_i,
  input  logic          async_rst_i,
  input  logic          wb_rst_i,
  input  logic          enable_i,
  output logic [aw-1:0] wbm_adr_o,
  output logic [dw-1:0] wbm_dat_o,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [2:0]    wbm_cti_o,
  output logic [1:0]    wbm_bte_o,
  input  logic [dw-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic          wbm_rty_i,
  output logic [11:0]   temp_o,
  output logic [11:0]   vccint_o,
  output logic [11:0]   vccaux_o,
  output logic [11:0]   vbram_o,
  output logic [3:0]    valid_o,
  output logic          sweep_done_o,
  output logic [7:0]    err_cnt_o
`ifdef XADC_POLLER_MINMAX_EN
  ,
  output logic [11:0]   temp_min_o,
  output logic [11:0]   temp_max_o
`endif
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0] PERIOD_M1 = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [11:0] min12(input logic [11:0] a, input logic [11:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [11:0] max12(input logic [11:0] a, input logic [11:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [aw-1:0] bus_addr(input logic [CHW-1:0] ch);
    logic [aw-1:0] a;
    a                 = '0;
    a[6:0]            = drp_addr(ch);
    a[DRP_WINDOW_BIT] = 1'b1;
    return a;
  endfunction

  state_t                 state_q, state_d;
  logic [PW-1:0]          period_q, period_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic                   again_q, again_d;
  logic [aw-1:0]          adr_q, adr_d;
  logic                   cyc_q, cyc_d;
  logic                   done_q, done_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [NCH-1:0][11:0]   res_q, res_d;
  logic [NCH-1:0]         valid_q, valid_d;
`ifdef XADC_POLLER_MINMAX_EN
  logic [11:0]            tmin_q, tmin_d;
  logic [11:0]            tmax_q, tmax_d;
`endif

  logic xfer_end;
  logic xfer_fail;
  logic xfer_again;
  logic unused_dat;

  // Low data nibble carries no conversion bits.
  assign unused_dat = ^wbm_dat_i;

  // Next-state logic: sweep sequencing, response handling and result capture.
  always_comb begin
    state_d    = state_q;
    period_d   = (period_q != '0) ? period_q - PW'(1) : period_q;
    wait_d     = wait_q;
    retry_d    = retry_q;
    ch_d       = ch_q;
    again_d    = again_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    done_d     = 1'b0;
    err_cnt_d  = err_cnt_q;
    res_d      = res_q;
    valid_d    = valid_q;
    xfer_end   = 1'b0;
    xfer_fail  = 1'b0;
    xfer_again = 1'b0;
`ifdef XADC_POLLER_MINMAX_EN
    tmin_d     = tmin_q;
    tmax_d     = tmax_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (period_q == '0 && enable_i) begin
          period_d = PERIOD_M1;
          ch_d     = CH_TEMP;
          wait_d   = '0;
          retry_d  = '0;
          again_d  = 1'b0;
          adr_d    = bus_addr(CH_TEMP);
          cyc_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end

      ST_REQ: begin
        wait_d = wait_q + TW'(1);
        // err outranks ack, ack outranks rty.
        if (wbm_err_i) begin
          xfer_end  = 1'b1;
          xfer_fail = 1'b1;
        end else if (wbm_ack_i) begin
          xfer_end       = 1'b1;
          res_d[ch_q]    = wbm_dat_i[15:4];
          valid_d[ch_q]  = 1'b1;
`ifdef XADC_POLLER_MINMAX_EN
          if (ch_q == CH_TEMP) begin
            tmin_d = min12(tmin_q, wbm_dat_i[15:4]);
            tmax_d = max12(tmax_q, wbm_dat_i[15:4]);
          end
`endif
        end else if (wbm_rty_i) begin
          xfer_end = 1'b1;
          if (retry_q < RETRY_LIM) begin
            xfer_again = 1'b1;
            retry_d    = retry_q + RW'(1);
          end else begin
            xfer_fail = 1'b1;
          end
        end else if (wait_d == TIMEOUT_T) begin
          xfer_end  = 1'b1;
          xfer_fail = 1'b1;
        end

        if (xfer_end) begin
          cyc_d   = 1'b0;
          again_d = xfer_again;
          state_d = ST_GAP;
        end
        if (xfer_fail) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end
      end

      ST_GAP: begin
        wait_d = '0;
        if (!enable_i) begin
          // Sweep abandoned between transfers: no completion pulse.
          retry_d = '0;
          state_d = ST_IDLE;
        end else if (again_q) begin
          cyc_d   = 1'b1;
          state_d = ST_REQ;
        end else if (ch_q == CH_VBRAM) begin
          retry_d = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          adr_d   = bus_addr(ch_q + CHW'(1));
          retry_d = '0;
          cyc_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Synchronous reset overrides everything, including an open transfer.
    if (wb_rst_i) begin
      state_d   = ST_IDLE;
      period_d  = '0;
      wait_d    = '0;
      retry_d   = '0;
      ch_d      = '0;
      again_d   = 1'b0;
      adr_d     = '0;
      cyc_d     = 1'b0;
      done_d    = 1'b0;
      err_cnt_d = '0;
      res_d     = '0;
      valid_d   = '0;
`ifdef XADC_POLLER_MINMAX_EN
      tmin_d    = 12'hFFF;
      tmax_d    = 12'h000;
`endif
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      wait_q    <= '0;
      retry_q   <= '0;
      ch_q      <= '0;
      again_q   <= 1'b0;
      adr_q     <= '0;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
      res_q     <= '0;
      valid_q   <= '0;
`ifdef XADC_POLLER_MINMAX_EN
      tmin_q    <= 12'hFFF;
      tmax_q    <= 12'h000;
`endif
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      wait_q    <= wait_d;
      retry_q   <= retry_d;
      ch_q      <= ch_d;
      again_q   <= again_d;
      adr_q     <= adr_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
`ifdef XADC_POLLER_MINMAX_EN
      tmin_q    <= tmin_d;
      tmax_q    <= tmax_d;
`endif
    end
  end

  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = '0;
  assign wbm_sel_o    = 4'b0011;
  assign wbm_we_o     = 1'b0;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_cti_o    = 3'b000;
  assign wbm_bte_o    = 2'b00;

  assign temp_o       = res_q[CH_TEMP];
  assign vccint_o     = res_q[CH_VCCINT];
  assign vccaux_o     = res_q[CH_VCCAUX];
  assign vbram_o      = res_q[CH_VBRAM];
  assign valid_o      = valid_q;
  assign sweep_done_o = done_q;
  assign err_cnt_o    = err_cnt_q;
`ifdef XADC_POLLER_MINMAX_EN
  assign temp_min_o   = tmin_q;
  assign temp_max_o   = tmax_q;
`endif

endmodule

// File: tb/tb_xadc_wb_poller.sv
// Self-checking bench for xadc_wb_poller: a configurable Wishbone slave,
// a bus monitor and a sweep-level reference model.
module tb_xadc_wb_poller;

  localparam int P_PERIOD  = 50;
  localparam int P_TIMEOUT = 10;
  localparam int P_RETRY   = 3;

  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_ERRACK = 2;
  localparam int M_NONE   = 3;
  localparam int M_RTY    = 4;

  logic        clk = 1'b0;
  logic        async_rst = 1'b1;
  logic        wb_rst = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [15:0] s_dat = 16'h0;
  logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [11:0] temp_o, vccint_o, vccaux_o, vbram_o;
  logic [3:0]  valid_o;
  logic        sweep_done_o;
  logic [7:0]  err_cnt_o;
`ifdef XADC_POLLER_MINMAX_EN
  logic [11:0] temp_min_o, temp_max_o;
`endif

  xadc_wb_poller #(
    .aw(8), .dw(16), .PERIOD(P_PERIOD), .TIMEOUT(P_TIMEOUT), .MAX_RETRY(P_RETRY)
  ) dut (
    .wb_clk_i(clk), .async_rst_i(async_rst), .wb_rst_i(wb_rst), .enable_i(enable),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(s_dat),
    .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty),
    .temp_o(temp_o), .vccint_o(vccint_o), .vccaux_o(vccaux_o), .vbram_o(vbram_o),
    .valid_o(valid_o), .sweep_done_o(sweep_done_o), .err_cnt_o(err_cnt_o)
`ifdef XADC_POLLER_MINMAX_EN
    , .temp_min_o(temp_min_o), .temp_max_o(temp_max_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave configuration, per channel index
  int          s_mode [4];
  int          s_lat  [4];
  int          s_rtyn [4];
  int          rty_left [4];
  logic [15:0] s_data [4];

  // Monitor state
  logic [7:0]  addr_q[$];
  int          len_q[$];
  int          start_q[$];
  int          done_cnt = 0;
  int          cur_len = 0;
  bit          prev_cyc = 1'b0;
  int          cyc_n = 0;
  int          mon_ch;

  // Reference model state
  logic [7:0]  exp_addr[$];
  int          exp_len[$];
  logic [11:0] exp_res [4];
  logic [3:0]  exp_valid;
  int          exp_err;

  function automatic int addr2ch(input logic [7:0] a);
    case (a)
      8'h80:   return 0;
      8'h81:   return 1;
      8'h82:   return 2;
      8'h86:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] ch2addr(input int ch);
    case (ch)
      0:       return 8'h80;
      1:       return 8'h81;
      2:       return 8'h82;
      default: return 8'h86;
    endcase
  endfunction

  always @(posedge clk) cyc_n++;

  // Slave responder and bus monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 16'h0;
    if (sweep_done_o) done_cnt++;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (!prev_cyc) begin
        addr_q.push_back(wbm_adr_o);
        if (wbm_adr_o == 8'h80) start_q.push_back(cyc_n);
        cur_len = 0;
      end
      cur_len++;
      mon_ch = addr2ch(wbm_adr_o);
      if (mon_ch >= 0 && cur_len > s_lat[mon_ch]) begin
        case (s_mode[mon_ch])
          M_ACK:    begin s_ack = 1'b1; s_dat = s_data[mon_ch]; end
          M_ERR:    s_err = 1'b1;
          M_ERRACK: begin s_err = 1'b1; s_ack = 1'b1; s_dat = s_data[mon_ch]; end
          M_RTY: begin
            if (rty_left[mon_ch] > 0) begin
              s_rty = 1'b1;
              rty_left[mon_ch]--;
            end else begin
              s_ack = 1'b1; s_dat = s_data[mon_ch];
            end
          end
          default: ;
        endcase
      end
    end else if (prev_cyc) begin
      len_q.push_back(cur_len);
    end
    prev_cyc = wbm_cyc_o && wbm_stb_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) exp_res[i] = 12'h0;
    exp_valid = 4'h0;
    exp_err   = 0;
  endtask

  task automatic clear_mon();
    addr_q.delete(); len_q.delete(); start_q.delete();
    exp_addr.delete(); exp_len.delete();
    done_cnt = 0;
    for (int i = 0; i < 4; i++) rty_left[i] = s_rtyn[i];
  endtask

  task automatic set_all(input int mode, input int lat);
    for (int i = 0; i < 4; i++) begin
      s_mode[i] = mode; s_lat[i] = lat; s_rtyn[i] = 0; s_data[i] = 16'($urandom);
    end
  endtask

  // Expected outcome of one complete sweep, from the per-channel slave behaviour.
  task automatic model_sweep();
    for (int ch = 0; ch < 4; ch++) begin
      case (s_mode[ch])
        M_ACK: begin
          exp_addr.push_back(ch2addr(ch)); exp_len.push_back(s_lat[ch] + 1);
          exp_res[ch] = s_data[ch][15:4]; exp_valid[ch] = 1'b1;
        end
        M_ERR, M_ERRACK: begin
          exp_addr.push_back(ch2addr(ch)); exp_len.push_back(s_lat[ch] + 1);
          if (exp_err < 255) exp_err++;
        end
        M_NONE: begin
          exp_addr.push_back(ch2addr(ch)); exp_len.push_back(P_TIMEOUT);
          if (exp_err < 255) exp_err++;
        end
        default: begin
          int tries;
          tries = (s_rtyn[ch] <= P_RETRY) ? s_rtyn[ch] + 1 : P_RETRY + 1;
          for (int t = 0; t < tries; t++) begin
            exp_addr.push_back(ch2addr(ch)); exp_len.push_back(s_lat[ch] + 1);
          end
          if (s_rtyn[ch] <= P_RETRY) begin
            exp_res[ch] = s_data[ch][15:4]; exp_valid[ch] = 1'b1;
          end else if (exp_err < 255) exp_err++;
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_temp"},   temp_o,    exp_res[0]);
    chk({tag, "_vccint"}, vccint_o,  exp_res[1]);
    chk({tag, "_vccaux"}, vccaux_o,  exp_res[2]);
    chk({tag, "_vbram"},  vbram_o,   exp_res[3]);
    chk({tag, "_valid"},  valid_o,   exp_valid);
    chk({tag, "_errcnt"}, err_cnt_o, exp_err);
  endtask

  task automatic run_sweep(input string tag);
    bit ok;
    clear_mon();
    model_sweep();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (sweep_done_o) ok = 1'b1;
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done_seen"}, ok, 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_nreq"}, addr_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < addr_q.size()) chk($sformatf("%s_adr%0d", tag, i), addr_q[i], exp_addr[i]);
      if (i < len_q.size())  chk($sformatf("%s_len%0d", tag, i), len_q[i], exp_len[i]);
    end
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cyc"},  wbm_cyc_o, 0);
    chk({tag, "_stb"},  wbm_stb_o, 0);
    chk({tag, "_adr"},  wbm_adr_o, 0);
    chk({tag, "_done"}, sweep_done_o, 0);
    check_outputs(tag);
  endtask

  initial begin
    bit found;
    int n81;
    reset_model();
    set_all(M_ACK, 0);
    for (int i = 0; i < 4; i++) rty_left[i] = 0;
    repeat (3) @(negedge clk);
    async_rst = 1'b0;
    @(negedge clk);

    // Reset state and constant bus fields
    check_zero("rst");
    chk("sel", wbm_sel_o, 4'b0011);
    chk("we",  wbm_we_o, 0);
    chk("cti", wbm_cti_o, 3'b000);
    chk("bte", wbm_bte_o, 2'b00);
    chk("dato", wbm_dat_o, 16'h0);

    // Plain sweep, 2-cycle slave
    set_all(M_ACK, 2);
    s_data[0] = 16'h9A30;
    run_sweep("ack");
    chk("ack_temp_lit", temp_o, 12'h9A3);
    chk("ack_valid_lit", valid_o, 4'hF);

    set_all(M_ACK, 0);
    for (int i = 0; i < 4; i++) s_lat[i] = $urandom_range(0, 3);
    run_sweep("ack_rnd");

    // Three retries then ack
    set_all(M_ACK, $urandom_range(0, 2));
    s_mode[1] = M_RTY; s_rtyn[1] = 3; s_data[1] = 16'h5550;
    run_sweep("rty3");
    n81 = 0;
    foreach (addr_q[i]) if (addr_q[i] == 8'h81) n81++;
    chk("rty3_n81", n81, 4);
    chk("rty3_vccint", vccint_o, 12'h555);
    chk("rty3_err", err_cnt_o, 0);

    // Retries exhausted
    set_all(M_ACK, 1);
    s_mode[1] = M_RTY; s_rtyn[1] = 4;
    run_sweep("rty4");
    chk("rty4_err", err_cnt_o, 1);
    chk("rty4_vccint", vccint_o, 12'h555);

    // err and ack together on temp
    set_all(M_ACK, 0);
    s_mode[0] = M_ERRACK;
    run_sweep("errack");

    // enable drops mid-sweep while channel 1 is in flight
    set_all(M_ACK, 0);
    s_lat[1] = 3;
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == 8'h81) found = 1'b1;
    end
    enable = 1'b0;
    repeat (100) @(negedge clk);
    exp_res[0] = s_data[0][15:4]; exp_res[1] = s_data[1][15:4];
    exp_valid[1:0] = 2'b11;
    chk("endrop_found", found, 1);
    chk("endrop_done", done_cnt, 0);
    chk("endrop_nreq", addr_q.size(), 2);
    chk("endrop_cyc", wbm_cyc_o, 0);
    check_outputs("endrop");

    // Synchronous reset mid-transfer
    set_all(M_NONE, 0);
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) found = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("srst_pre_cyc", wbm_cyc_o, 1);
    wb_rst = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    reset_model();
    chk("srst_found", found, 1);
    check_zero("srst");
    @(negedge clk);
    wb_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("srst_after_err", err_cnt_o, 0);

    // Timeout at VCCAUX
    set_all(M_ACK, 1);
    s_mode[2] = M_NONE;
    run_sweep("tmo");
    chk("tmo_valid2", valid_o[2], 0);

    // Randomised sweeps
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) begin
        s_mode[i] = $urandom_range(0, 4);
        s_lat[i]  = $urandom_range(0, 3);
        s_rtyn[i] = $urandom_range(0, 5);
        s_data[i] = 16'($urandom);
      end
      run_sweep($sformatf("rnd%0d", r));
    end

    // Sweep start spacing with a continuous-ack slave
    set_all(M_ACK, 0);
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (start_q.size() >= 4) found = 1'b1;
    end
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("period_found", found, 1);
    for (int i = 1; i < 4; i++)
      if (i < start_q.size()) chk($sformatf("period_gap%0d", i), start_q[i] - start_q[i-1], P_PERIOD);
    for (int i = 0; i < 4; i++) exp_res[i] = s_data[i][15:4];
    exp_valid = 4'hF;
    check_outputs("period");

    // Asynchronous reset mid-transfer
    set_all(M_ACK, 0);
    s_mode[2] = M_NONE;
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == 8'h82) found = 1'b1;
    end
    #1 async_rst = 1'b1;
    #1;
    reset_model();
    chk("arst_found", found, 1);
    check_zero("arst");
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    async_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("arst_rel");

`ifdef XADC_POLLER_MINMAX_EN
    chk("mm_rst_min", temp_min_o, 12'hFFF);
    chk("mm_rst_max", temp_max_o, 12'h000);
    set_all(M_ACK, 0); s_data[0] = 16'h4000; run_sweep("mm1");
    set_all(M_ACK, 0); s_data[0] = 16'h3000; run_sweep("mm2");
    set_all(M_ACK, 0); s_data[0] = 16'h5000; run_sweep("mm3");
    chk("mm_min", temp_min_o, 12'h300);
    chk("mm_max", temp_max_o, 12'h500);
`endif

    // Error counter saturation
    set_all(M_ERR, 0);
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (err_cnt_o == 8'hFF) found = 1'b1;
    end
    repeat (120) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    chk("sat_reached", found, 1);
    chk("sat_hold", err_cnt_o, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
